// File: rtl/collector_pkg.sv
// -----------------------------------------------------------------------------
// collector_pkg
// Shared types and helpers for serial_word_collector.
//   state_t   : collector FSM state (COLLECT while gathering bits, FULL while a
//               completed word waits in the shift register for the output slot)
//   popcount  : number of ones in a vector of up to MAX_WIDTH bits
//   bit_pos   : storage position of the n-th accepted bit for either bit order
// -----------------------------------------------------------------------------
package collector_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Widest word the helpers handle; callers zero-extend narrower words.
    localparam int MAX_WIDTH = 64;

    // Ones count of a zero-extended word. Zero padding adds nothing, so the
    // result is exact for any WIDTH up to MAX_WIDTH.
    function automatic int unsigned popcount(input logic [MAX_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Position in the assembled word for the accepted bit with index cnt.
    function automatic int unsigned bit_pos(input int unsigned cnt,
                                            input int unsigned width,
                                            input bit          msb_first);
        return msb_first ? (width - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/serial_word_collector.sv
// -----------------------------------------------------------------------------
// serial_word_collector
// Gathers WIDTH accepted serial bits into a word and presents it, together with
// its ones count, on a valid/ready output port. One completed word can sit in
// the output register while a second sits in the shift register; with both
// occupied the serial side is back-pressured.
//
// Ports
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   bit_in      : serial data bit
//   bit_valid   : bit_in is meaningful this cycle
//   bit_ready   : collector accepts a bit this cycle (decode of state only)
//   word_out    : assembled word
//   ones_out    : number of ones in word_out
//   word_valid  : word_out/ones_out hold an unconsumed word
//   word_ready  : consumer takes the word this cycle
// -----------------------------------------------------------------------------
module serial_word_collector
    import collector_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic [CW-1:0]    ones_out,
    output logic             word_valid,
    input  logic             word_ready
);

    localparam int BW = $clog2(WIDTH);

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;
    logic [BW-1:0]    pos;
    logic             accept;
    logic             consume;
    logic             last_bit;

    // bit_ready depends on state alone so an upstream bit_valid may safely
    // depend on it without forming a loop through word_ready.
    assign bit_ready = (state == COLLECT);
    assign accept    = bit_valid && bit_ready;
    assign consume   = word_valid && word_ready;
    assign last_bit  = (bit_cnt == BW'(WIDTH - 1));
    assign pos       = BW'(bit_pos(32'(bit_cnt), WIDTH, MSB_FIRST));

    // Shift register with the incoming bit already merged in, so the word
    // completed by the final bit can be loaded straight into the output slot.
    always_comb begin
        next_word      = shift_reg;
        next_word[pos] = bit_in;
    end

    // FSM, bit counter, shift register and output register.
    // In COLLECT a consumption without a reload frees the output slot; a
    // completing bit either reloads the slot on the same edge (seamless
    // hand-over when the old word is being taken) or parks the word and
    // moves to FULL. In FULL the parked word moves out as soon as the
    // current one is consumed, keeping word_valid high with no bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= COLLECT;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            word_out   <= '0;
            ones_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (consume) begin
                        word_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (last_bit) begin
                            if (!word_valid || word_ready) begin
                                word_out   <= next_word;
                                ones_out   <= CW'(popcount(MAX_WIDTH'(next_word)));
                                word_valid <= 1'b1;
                                bit_cnt    <= '0;
                                shift_reg  <= '0;
                            end else begin
                                shift_reg <= next_word;
                                state     <= FULL;
                            end
                        end else begin
                            shift_reg <= next_word;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (consume) begin
                        word_out  <= shift_reg;
                        ones_out  <= CW'(popcount(MAX_WIDTH'(shift_reg)));
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// -----------------------------------------------------------------------------
// tb_serial_word_collector
// Drives one serial stream into two collectors (LSB-first and MSB-first) and
// checks both against a word-level scoreboard built from the bits the bench
// itself sends, plus directed literal checks for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_serial_word_collector;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             bit_in;
    logic             bit_valid;
    logic             word_ready;

    logic             lsb_bit_ready, msb_bit_ready;
    logic [WIDTH-1:0] lsb_word, msb_word;
    logic [CW-1:0]    lsb_ones, msb_ones;
    logic             lsb_valid, msb_valid;

    int compared   = 0;
    int mismatched = 0;
    bit checks_on  = 1'b0;

    logic [WIDTH-1:0] q_lsb[$];
    logic [WIDTH-1:0] q_msb[$];
    int               model_cnt = 0;
    logic [WIDTH-1:0] model_lsb = '0;
    logic [WIDTH-1:0] model_msb = '0;

    always #5 clock = ~clock;

    serial_word_collector #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clock      (clock),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (lsb_bit_ready),
        .word_out   (lsb_word),
        .ones_out   (lsb_ones),
        .word_valid (lsb_valid),
        .word_ready (word_ready)
    );

    serial_word_collector #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clock      (clock),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (msb_bit_ready),
        .word_out   (msb_word),
        .ones_out   (msb_ones),
        .word_valid (msb_valid),
        .word_ready (word_ready)
    );

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge with inputs set for the coming rising edge:
    // compares outputs with the scoreboard, records the handshakes that the
    // rising edge will perform, then advances to the next falling edge.
    task automatic cycle();
        bit model_ready;
        if (checks_on) begin
            checkOutput("lsb_word_valid", 32'(lsb_valid), 32'(q_lsb.size() > 0));
            checkOutput("msb_word_valid", 32'(msb_valid), 32'(q_msb.size() > 0));
            checkOutput("lsb_bit_ready", 32'(lsb_bit_ready), 32'(q_lsb.size() < 2));
            checkOutput("msb_bit_ready", 32'(msb_bit_ready), 32'(q_msb.size() < 2));
            if (q_lsb.size() > 0) begin
                checkOutput("lsb_word_out", 32'(lsb_word), 32'(q_lsb[0]));
                checkOutput("lsb_ones_out", 32'(lsb_ones), 32'($countones(q_lsb[0])));
                checkOutput("msb_word_out", 32'(msb_word), 32'(q_msb[0]));
                checkOutput("msb_ones_out", 32'(msb_ones), 32'($countones(q_msb[0])));
            end
        end
        model_ready = (q_lsb.size() < 2);
        if (reset) begin
            q_lsb.delete();
            q_msb.delete();
            model_cnt = 0;
            model_lsb = '0;
            model_msb = '0;
        end else begin
            if (word_ready && q_lsb.size() > 0) begin
                void'(q_lsb.pop_front());
                void'(q_msb.pop_front());
            end
            if (bit_valid && model_ready) begin
                model_lsb[model_cnt]           = bit_in;
                model_msb[WIDTH - 1 - model_cnt] = bit_in;
                model_cnt++;
                if (model_cnt == WIDTH) begin
                    q_lsb.push_back(model_lsb);
                    q_msb.push_back(model_msb);
                    model_cnt = 0;
                    model_lsb = '0;
                    model_msb = '0;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    // Presents one bit until the collector takes it (bounded wait).
    task automatic applyStimulus(input logic b);
        bit accepted;
        accepted  = 1'b0;
        bit_valid = 1'b1;
        bit_in    = b;
        for (int i = 0; i < 64 && !accepted; i++) begin
            accepted = (q_lsb.size() < 2) && !reset;
            cycle();
        end
        if (!accepted) checkOutput("bit_accept_timeout", 32'(accepted), 32'd1);
        bit_valid = 1'b0;
    endtask

    // Sends a word LSB first, optionally with random idle gaps carrying junk.
    task automatic sendWord(input logic [WIDTH-1:0] w, input bit gaps);
        for (int i = 0; i < WIDTH; i++) begin
            if (gaps) begin
                for (int g = 0; g < 6 && $urandom_range(0, 1) == 0; g++) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom_range(0, 1));
                    cycle();
                end
            end
            applyStimulus(w[i]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        @(negedge clock);
        cycle();
        cycle();
        reset = 1'b0;
        $display("[TB] reset released");
        checkOutput("reset_word_valid", 32'(lsb_valid), 32'd0);
        checkOutput("reset_word_out", 32'(lsb_word), 32'h00);
        checkOutput("reset_ones_out", 32'(lsb_ones), 32'd0);
        checkOutput("reset_bit_ready", 32'(lsb_bit_ready), 32'd1);
        checks_on = 1'b1;

        // Contiguous bits 1,0,1,1,0,0,0,1 with the consumer always ready.
        $display("[TB] basic word, both bit orders");
        word_ready = 1'b1;
        sendWord(8'h8D, 1'b0);
        checkOutput("t1_lsb_valid", 32'(lsb_valid), 32'd1);
        checkOutput("t1_lsb_word", 32'(lsb_word), 32'h8D);
        checkOutput("t1_lsb_ones", 32'(lsb_ones), 32'd4);
        checkOutput("t2_msb_word", 32'(msb_word), 32'hB1);
        checkOutput("t2_msb_ones", 32'(msb_ones), 32'd4);
        cycle();
        checkOutput("t1_valid_drop", 32'(lsb_valid), 32'd0);

        // Back-pressure: two words held, then a one-cycle ready pulse.
        $display("[TB] back-pressure with two held words");
        word_ready = 1'b0;
        sendWord(8'h8D, 1'b0);
        sendWord(8'hFF, 1'b0);
        checkOutput("t3_bit_ready_low", 32'(lsb_bit_ready), 32'd0);
        checkOutput("t3_held_word", 32'(lsb_word), 32'h8D);
        cycle();
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
        checkOutput("t3_word_ff", 32'(lsb_word), 32'hFF);
        checkOutput("t3_ones_8", 32'(lsb_ones), 32'd8);
        checkOutput("t3_valid", 32'(lsb_valid), 32'd1);
        checkOutput("t3_bit_ready_high", 32'(lsb_bit_ready), 32'd1);
        word_ready = 1'b1;
        cycle();

        // Random bit_valid gaps with junk on bit_in while invalid.
        $display("[TB] gapped stream");
        sendWord(8'h3C, 1'b1);
        checkOutput("t4_word", 32'(lsb_word), 32'h3C);
        checkOutput("t4_ones", 32'(lsb_ones), 32'd4);
        cycle();

        // Reset mid-word discards the partial bits.
        $display("[TB] reset mid-word");
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checkOutput("t5_valid_after_reset", 32'(lsb_valid), 32'd0);
        sendWord(8'h00, 1'b0);
        checkOutput("t5_valid", 32'(lsb_valid), 32'd1);
        checkOutput("t5_word", 32'(lsb_word), 32'h00);
        checkOutput("t5_ones", 32'(lsb_ones), 32'd0);
        cycle();

        // Final bit of 0xA5 on the same edge the held 0x5A is consumed.
        $display("[TB] simultaneous consume and completion");
        word_ready = 1'b0;
        sendWord(8'h5A, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'((8'hA5 >> i) & 8'h01));
        word_ready = 1'b1;
        applyStimulus(1'b1);
        checkOutput("t6_valid", 32'(lsb_valid), 32'd1);
        checkOutput("t6_word", 32'(lsb_word), 32'hA5);
        checkOutput("t6_ones", 32'(lsb_ones), 32'd4);
        cycle();
        checkOutput("t6_no_repeat", 32'(lsb_valid), 32'd0);
        cycle();

        checkOutput("scoreboard_empty", 32'(q_lsb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
